// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV32 pipeline. Arbitrates
//   load-use hazards, multi-cycle mul/div occupancy of EX, instruction and
//   data memory wait, and taken-branch redirects (including a branch taken
//   while a fetch is still outstanding).
//
// Parameters
//   MD_LAT : freeze cycles applied for one mul/div op in EX (>= 1)
//   CNT_W  : width of the saturating stall-cycle counter
//
// Ports
//   clk, rst                 : clock (rising edge), async active-low reset
//   id_rs1/2, id_rs1/2_used  : source registers of the ID instruction
//   ex_valid, ex_rd          : EX occupancy and destination register
//   ex_mem_read, ex_muldiv   : EX instruction is a load / mul-div
//   ex_br_taken              : branch/jump resolved taken in EX
//   imem_wait, dmem_wait     : fetch / data memory not ready this cycle
//   stall[1:0]               : bit0 freezes PC+IF/ID, bit1 freezes ID/EX+EX
//   pc_hold, pc_redirect     : PC hold / load branch target
//   ifid_flush               : zero IF/ID
//   idex_bubble, exmem_bubble: NOP insertion into ID/EX, EX/MEM
//   state                    : 0 RUN, 1 MD_BUSY, 2 FLUSH_PEND
//   stall_cnt                : cycles with pc_hold=1, saturating
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_muldiv,
  input  logic             ex_br_taken,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic [1:0]       stall,
  output logic             pc_hold,
  output logic             pc_redirect,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MD_CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_MD_BUSY    = 2'd1,
    S_FLUSH_PEND = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                md_done_q, md_done_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic       lu_hz, md_start, md_busy, freeze, br_acc;
  logic [1:0] stall_c;
  logic       pc_hold_c, pc_redirect_c, ifid_flush_c, idex_bubble_c, exmem_bubble_c;

  // Hazard detection
  always_comb begin
    lu_hz = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
            ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    md_busy = (state_q == S_MD_BUSY);
    // md_done masks the op that just finished and is still sitting in EX
    // on the release cycle, so it cannot start a second freeze.
    md_start = (state_q == S_RUN) & ex_valid & ex_muldiv & ~md_done_q & ~dmem_wait;
    freeze   = dmem_wait | md_busy | md_start;
    br_acc   = ex_br_taken & ex_valid & ~freeze;
  end

  // Output arbitration (fixed priority)
  always_comb begin
    stall_c        = 2'b00;
    pc_hold_c      = 1'b0;
    pc_redirect_c  = 1'b0;
    ifid_flush_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    if (freeze) begin
      stall_c        = 2'b11;
      pc_hold_c      = 1'b1;
      // While memory stalls, EX/MEM must keep its contents rather than
      // take a bubble.
      exmem_bubble_c = (md_busy | md_start) & ~dmem_wait;
    end else if (br_acc) begin
      pc_redirect_c = 1'b1;
      ifid_flush_c  = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (lu_hz) begin
      stall_c       = 2'b01;
      pc_hold_c     = 1'b1;
      idex_bubble_c = 1'b1;
    end else if (imem_wait) begin
      pc_hold_c    = 1'b1;
      ifid_flush_c = 1'b1;
    end
    // The outstanding fetch is wrong-path: keep discarding until it lands,
    // including the cycle it finally arrives.
    if (state_q == S_FLUSH_PEND) begin
      ifid_flush_c = 1'b1;
      pc_hold_c    = imem_wait | freeze;
    end
  end

  // Outputs forced low while reset is asserted
  always_comb begin
    stall        = rst ? stall_c        : 2'b00;
    pc_hold      = rst ? pc_hold_c      : 1'b0;
    pc_redirect  = rst ? pc_redirect_c  : 1'b0;
    ifid_flush   = rst ? ifid_flush_c   : 1'b0;
    idex_bubble  = rst ? idex_bubble_c  : 1'b0;
    exmem_bubble = rst ? exmem_bubble_c : 1'b0;
    state        = state_q;
    stall_cnt    = stall_cnt_q;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    md_cnt_d    = md_cnt_q;
    md_done_d   = md_done_q;
    stall_cnt_d = stall_cnt_q;

    if (md_done_q && !stall_c[1]) begin
      md_done_d = 1'b0;
    end

    unique case (state_q)
      S_RUN: begin
        if (md_start) begin
          if (MD_LAT > 1) begin
            state_d  = S_MD_BUSY;
            md_cnt_d = MD_CNT_W'(MD_LAT - 1);
          end else begin
            md_done_d = 1'b1;
          end
        end else if (br_acc && imem_wait) begin
          state_d = S_FLUSH_PEND;
        end
      end
      S_MD_BUSY: begin
        if (!dmem_wait) begin
          if (md_cnt_q == MD_CNT_W'(1)) begin
            state_d   = S_RUN;
            md_cnt_d  = '0;
            md_done_d = 1'b1;
          end else begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
          end
        end
      end
      S_FLUSH_PEND: begin
        if (!imem_wait) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (pc_hold_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      md_cnt_q    <= '0;
      md_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_done_q   <= md_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used;
  logic             ex_valid, ex_mem_read, ex_muldiv, ex_br_taken;
  logic             imem_wait, dmem_wait;
  logic [1:0]       stall;
  logic             pc_hold, pc_redirect, ifid_flush, idex_bubble, exmem_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv), .ex_br_taken(ex_br_taken),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait),
    .stall(stall), .pc_hold(pc_hold), .pc_redirect(pc_redirect),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .state(state), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_muldiv = 1'b0; ex_br_taken = 1'b0;
    imem_wait = 1'b0; dmem_wait = 1'b0;
  endtask

  // Outputs packed as {stall, pc_hold, pc_redirect, ifid_flush, idex_bubble, exmem_bubble, state}
  task automatic chk_o(input string tag, input logic [1:0] st, input logic ph,
                       input logic rd, input logic fl, input logic ib,
                       input logic eb, input logic [1:0] sq);
    logic [8:0] obs, exp_v;
    obs   = {stall, pc_hold, pc_redirect, ifid_flush, idex_bubble, exmem_bubble, state};
    exp_v = {st, ph, rd, fl, ib, eb, sq};
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] exp_v);
    n_cmp++;
    assert (stall_cnt === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, stall_cnt, exp_v);
    end
  endtask

  // Advance to the next falling edge; inputs change here, checks follow #1 later.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    // Reset with busy-looking inputs: everything must read 0
    ex_valid = 1'b1; ex_muldiv = 1'b1; imem_wait = 1'b1; ex_br_taken = 1'b1;
    nxt(); #1;
    chk_o("reset_outputs", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    chk_cnt("reset_cnt", 0);
    nxt(); clear_in(); rst = 1'b1; #1;
    chk_o("idle", 2'b00, 0, 0, 0, 0, 0, 2'd0);

    // Load-use on rs2
    nxt(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5;
    id_rs1 = 5'd3; id_rs1_used = 1; id_rs2 = 5'd5; id_rs2_used = 1; #1;
    chk_o("loaduse", 2'b01, 1, 0, 0, 1, 0, 2'd0);
    nxt(); clear_in(); #1;
    chk_o("loaduse_next", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    chk_cnt("cnt_after_lu", 1);

    // ex_rd = 0 never hazards
    nxt(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd0; id_rs2 = 5'd0; id_rs2_used = 1; #1;
    chk_o("rd_zero", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    // matching register but not actually read
    nxt(); clear_in(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_rs2_used = 0; id_rs1 = 5'd3; id_rs1_used = 1; #1;
    chk_o("rs2_unused", 2'b00, 0, 0, 0, 0, 0, 2'd0);

    // Load-use on rs1 together with imem_wait: load-use wins
    nxt(); clear_in(); ex_valid = 1; ex_mem_read = 1; ex_rd = 5'd7;
    id_rs1 = 5'd7; id_rs1_used = 1; imem_wait = 1; #1;
    chk_o("lu_and_imem", 2'b01, 1, 0, 0, 1, 0, 2'd0);

    // imem_wait alone
    nxt(); clear_in(); imem_wait = 1; #1;
    chk_o("imem_wait", 2'b00, 1, 0, 1, 0, 0, 2'd0);
    nxt(); clear_in(); #1;
    chk_cnt("cnt_after_imem", 3);

    // mul/div held 5 cycles
    nxt(); ex_valid = 1; ex_muldiv = 1; #1;
    chk_o("md_c1", 2'b11, 1, 0, 0, 0, 1, 2'd0);
    nxt(); #1; chk_o("md_c2", 2'b11, 1, 0, 0, 0, 1, 2'd1);
    nxt(); #1; chk_o("md_c3", 2'b11, 1, 0, 0, 0, 1, 2'd1);
    nxt(); #1; chk_o("md_c4", 2'b11, 1, 0, 0, 0, 1, 2'd1);
    nxt(); #1; chk_o("md_c5_release", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    chk_cnt("cnt_after_md", 7);
    nxt(); clear_in(); #1;
    chk_o("md_idle", 2'b00, 0, 0, 0, 0, 0, 2'd0);

    // mul/div with dmem_wait on the 2nd freeze cycle
    nxt(); ex_valid = 1; ex_muldiv = 1; #1;
    chk_o("mdw_c1", 2'b11, 1, 0, 0, 0, 1, 2'd0);
    nxt(); dmem_wait = 1; #1;
    chk_o("mdw_c2_dwait", 2'b11, 1, 0, 0, 0, 0, 2'd1);
    nxt(); dmem_wait = 0; #1; chk_o("mdw_c3", 2'b11, 1, 0, 0, 0, 1, 2'd1);
    nxt(); #1; chk_o("mdw_c4", 2'b11, 1, 0, 0, 0, 1, 2'd1);
    nxt(); #1; chk_o("mdw_c5", 2'b11, 1, 0, 0, 0, 1, 2'd1);
    nxt(); #1; chk_o("mdw_c6_release", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    chk_cnt("cnt_after_mdw", 12);
    nxt(); clear_in(); #1;

    // dmem_wait alone freezes without bubbling EX/MEM
    dmem_wait = 1; #1;
    chk_o("dmem_only", 2'b11, 1, 0, 0, 0, 0, 2'd0);
    nxt(); clear_in(); #1;
    chk_cnt("cnt_after_dmem", 13);

    // Branch taken together with load-use: branch wins
    ex_valid = 1; ex_br_taken = 1; ex_mem_read = 1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_rs2_used = 1; #1;
    chk_o("br_over_lu", 2'b00, 0, 1, 1, 1, 0, 2'd0);

    // Branch taken during pending fetch
    nxt(); clear_in(); ex_valid = 1; ex_br_taken = 1; imem_wait = 1; #1;
    chk_o("br_imem_c0", 2'b00, 0, 1, 1, 1, 0, 2'd0);
    nxt(); clear_in(); imem_wait = 1; #1;
    chk_o("fp_c1", 2'b00, 1, 0, 1, 0, 0, 2'd2);
    nxt(); #1; chk_o("fp_c2", 2'b00, 1, 0, 1, 0, 0, 2'd2);
    nxt(); #1; chk_o("fp_c3", 2'b00, 1, 0, 1, 0, 0, 2'd2);
    nxt(); imem_wait = 0; #1;
    chk_o("fp_land", 2'b00, 0, 0, 1, 0, 0, 2'd2);
    nxt(); #1;
    chk_o("fp_done", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    chk_cnt("cnt_after_fp", 16);

    // Reset during MD_BUSY with md_cnt=2
    nxt(); ex_valid = 1; ex_muldiv = 1; #1;
    chk_o("rmd_c1", 2'b11, 1, 0, 0, 0, 1, 2'd0);
    nxt(); #1; chk_o("rmd_c2", 2'b11, 1, 0, 0, 0, 1, 2'd1);
    nxt(); rst = 1'b0; #1;
    chk_o("rmd_reset", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    chk_cnt("rmd_reset_cnt", 0);
    nxt(); clear_in(); rst = 1'b1; #1;
    chk_o("rmd_after", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    nxt(); #1;
    chk_o("rmd_after2", 2'b00, 0, 0, 0, 0, 0, 2'd0);
    chk_cnt("rmd_after_cnt", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Produces the 2-bit stall vector, the IF/ID flush (drives the IF/ID register's br input), the PC hold and the ID/EX and EX/MEM bubble controls.
- Arbitrates load-use hazards, multi-cycle mul/div occupancy of EX, instruction/data memory wait, and taken-branch redirects, including a branch taken during a pending fetch.

Parameters:
- MD_LAT, 4, freeze cycles applied for one mul/div op in EX (must be >= 1).
- CNT_W, 32, width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  source actually read.
- ex_valid  in  1  EX holds a real instruction.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_muldiv  in  1  EX instruction is mul/div.
- ex_br_taken  in  1  branch/jump resolved taken in EX.
- imem_wait  in  1  fetch data not ready this cycle.
- dmem_wait  in  1  data memory not ready this cycle.
- stall  out  2  bit0 freezes PC and IF/ID; bit1 freezes ID/EX and EX.
- pc_hold  out  1  PC must not advance.
- pc_redirect  out  1  load branch target into PC this cycle.
- ifid_flush  out  1  zero IF/ID (NOP insert).
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_bubble  out  1  load NOP into EX/MEM.
- state  out  2  FSM state: 0 RUN, 1 MD_BUSY, 2 FLUSH_PEND.
- stall_cnt  out  CNT_W  cycles with pc_hold=1, saturating.

Behaviour:
- Outputs are combinational from registered state plus current inputs. While rst=0, every output is 0 and state is RUN; md_cnt, md_done and stall_cnt are cleared asynchronously. Reset mid-MD_BUSY or mid-FLUSH_PEND abandons the operation with no residual flush.
- lu_hz = ex_valid & ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Freeze set F = dmem_wait | state==MD_BUSY | md_start.
  - md_start = state==RUN & ex_valid & ex_muldiv & ~md_done & ~dmem_wait.
- Branch acceptance: br_acc = ex_br_taken & ex_valid & ~F.
- Priority per cycle:
  1. F: stall=11, pc_hold=1, exmem_bubble = (MD_BUSY|md_start) & ~dmem_wait.
  2. br_acc: pc_redirect=1, ifid_flush=1, idex_bubble=1, stall=00, pc_hold=0. Suppresses lu_hz.
  3. lu_hz: stall=01, pc_hold=1, idex_bubble=1, ifid_flush=0 (ID instruction preserved).
  4. imem_wait: pc_hold=1, ifid_flush=1, stall=00.
  5. Otherwise all outputs 0.
- In FLUSH_PEND, ifid_flush=1 regardless of priority; pc_hold = imem_wait | F.
- FSM:
  - RUN -> MD_BUSY on md_start when MD_LAT>1; md_cnt loads MD_LAT-1.
  - If MD_LAT==1, stay in RUN and set md_done.
  - MD_BUSY: md_cnt decrements each cycle dmem_wait=0 and holds when dmem_wait=1. When md_cnt==1 with dmem_wait=0: go to RUN, md_cnt->0, set md_done.
  - md_done clears on the next cycle where stall[1]=0. This blocks re-triggering by the same op still in EX on the release cycle.
  - RUN -> FLUSH_PEND when br_acc & imem_wait (the in-flight fetch is wrong-path).
  - FLUSH_PEND -> RUN on the first cycle with imem_wait=0. ifid_flush stays 1 in that cycle too, discarding the late fetch.
  - ex_muldiv in FLUSH_PEND is ignored; EX holds bubbles there.
- Total freeze per mul/div op is exactly MD_LAT cycles plus the number of dmem_wait cycles overlapping it.
- stall_cnt increments on each rising edge where pc_hold=1 and saturates at all-ones.
- ex_rd==0 never creates a hazard. A simultaneous lu_hz and imem_wait resolves to the lu_hz outputs.

Test Plan:
- Load x5 in EX, ID uses rs2=x5 with rs2_used=1 -> one cycle of stall=01, pc_hold=1, idex_bubble=1. Next cycle (load in MEM) all outputs 0. Same stimulus with ex_rd=0 -> no stall.
- MD_LAT=4, ex_muldiv held high 5 cycles -> stall=11 and exmem_bubble=1 for exactly 4 cycles, state 0->1->1->1->0. Cycle 5 has stall=00 and no re-trigger. stall_cnt=4.
- Mul/div with dmem_wait=1 on the 2nd freeze cycle -> freeze lasts 5 cycles; exmem_bubble=0 in the dmem_wait cycle.
- ex_br_taken with lu_hz the same cycle -> pc_redirect=1, ifid_flush=1, idex_bubble=1, stall=00.
- ex_br_taken while imem_wait=1, imem_wait held 3 more cycles -> state=2 for those cycles with ifid_flush=1. ifid_flush=1 also in the first imem_wait=0 cycle, then state=0 and ifid_flush=0.
- rst pulled low during MD_BUSY (md_cnt=2) -> all outputs 0 immediately and stall_cnt=0. After release with ex_muldiv=0 -> state=0, no freeze.
